stc_frame_tracker: RTL and testbench

//  Acquires and tracks STC frame timing from the pilot detector's peak pulses and produces the

---
 rtl/stc_frame_tracker_pkg.sv | 18 +
 rtl/stc_frame_tracker_mod_counter.sv | 26 ++
 rtl/stc_frame_tracker.sv | 137 +++++++++++++
 tb/tb_stc_frame_tracker.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/stc_frame_tracker_pkg.sv
// rtl/stc_frame_tracker_pkg.sv - shared STC frame constants, state encoding and index helper
package stc_frame_tracker_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int STC_FRAME_SAMPLES = 13312;
  localparam int STC_PILOT_SAMPLES = 512;

  // Next sample index with wrap from n-1 back to 0
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stc_frame_tracker_mod_counter.sv
// rtl/stc_frame_tracker_mod_counter.sv - modulo-N counter with load-to-zero and enable
module stc_mod_counter
  import stc_frame_tracker_pkg::*;
#(
  parameter int N = STC_FRAME_SAMPLES,
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count modulo N; a clear wins over an advance in the same clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= W'(wrap_inc(int'(count), N));
    end
  end

endmodule

// File: rtl/stc_frame_tracker.sv
// rtl/stc_frame_tracker.sv - STC frame acquisition, flywheel tracking and frame control outputs
module stc_frame_tracker
  import stc_frame_tracker_pkg::*;
#(
  parameter int FRAME_SAMPLES = STC_FRAME_SAMPLES,
  parameter int PILOT_SAMPLES = STC_PILOT_SAMPLES,
  parameter int WINDOW        = 4,
  parameter int MAX_MISSES    = 3,
  parameter int CNT_W         = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkEn,
  input  logic        validIn,
  input  logic        pilotFound,
  output logic        startOfFrame,
  output logic        validOut,
  output logic        lastSampleReset,
  output logic        locked,
  output logic [1:0]  missCount,
  output logic [15:0] frameCount
);

  localparam logic [CNT_W-1:0] WIN_HI    = CNT_W'(FRAME_SAMPLES - WINDOW);
  localparam logic [CNT_W-1:0] WIN_LO    = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] CLOSE_IDX = CNT_W'(WINDOW + 1);
  localparam logic [CNT_W-1:0] PILOT_END = CNT_W'(PILOT_SAMPLES);
  localparam logic [1:0]       MISS_LAST = 2'(MAX_MISSES - 1);

  state_t           state, state_n;
  logic             strobe;
  logic [CNT_W-1:0] last_idx;
  logic [CNT_W-1:0] cur_idx;
  logic [CNT_W-1:0] eff_idx;
  logic             in_win, at_close;
  logic             win_acc, win_acc_n;
  logic             accept;
  logic             sof_n, lsr_n, vout_n;
  logic [1:0]       miss_n;

  assign strobe = clkEn & validIn;

  // last_idx holds the index given to the previous strobe; an accepted pilot pins it to 0
  stc_mod_counter #(
    .N(FRAME_SAMPLES),
    .W(CNT_W)
  ) u_idx (
    .clk  (clk),
    .reset(reset),
    .en   (strobe),
    .clr  (accept),
    .count(last_idx)
  );

  assign cur_idx  = CNT_W'(wrap_inc(int'(last_idx), FRAME_SAMPLES));
  assign in_win   = (cur_idx >= WIN_HI) || (cur_idx <= WIN_LO);
  assign at_close = (cur_idx == CLOSE_IDX);
  assign eff_idx  = accept ? '0 : cur_idx;
  assign locked   = (state == LOCKED);

  // Next-state and output decode for the acquisition/tracking FSM, evaluated per strobe
  always_comb begin
    state_n   = state;
    win_acc_n = win_acc;
    miss_n    = missCount;
    accept    = 1'b0;
    sof_n     = 1'b0;
    lsr_n     = 1'b0;
    if (strobe) begin
      case (state)
        SEARCH: begin
          if (pilotFound) begin
            accept    = 1'b1;
            win_acc_n = 1'b1;
            state_n   = VERIFY;
          end
        end
        VERIFY: begin
          if (pilotFound && in_win && !win_acc) begin
            accept    = 1'b1;
            win_acc_n = 1'b1;
            miss_n    = 2'd0;
            sof_n     = 1'b1;
            state_n   = LOCKED;
          end else if (at_close) begin
            win_acc_n = 1'b0;
            if (!win_acc) state_n = SEARCH;
          end
        end
        LOCKED: begin
          if (pilotFound && in_win && !win_acc) begin
            accept    = 1'b1;
            win_acc_n = 1'b1;
            miss_n    = 2'd0;
            sof_n     = 1'b1;
          end else if (at_close) begin
            win_acc_n = 1'b0;
            if (!win_acc) begin
              if (missCount == MISS_LAST) begin
                state_n = SEARCH;
                lsr_n   = 1'b1;
                miss_n  = 2'd0;
              end else begin
                miss_n = missCount + 2'd1;
                sof_n  = 1'b1;
              end
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end
    vout_n = strobe && (state_n == LOCKED) && (eff_idx >= PILOT_END);
  end

  // State and registered outputs; everything holds while clkEn is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= SEARCH;
      win_acc         <= 1'b0;
      missCount       <= 2'd0;
      startOfFrame    <= 1'b0;
      lastSampleReset <= 1'b0;
      validOut        <= 1'b0;
      frameCount      <= 16'd0;
    end else if (clkEn) begin
      state           <= state_n;
      win_acc         <= win_acc_n;
      missCount       <= miss_n;
      startOfFrame    <= sof_n;
      lastSampleReset <= lsr_n;
      validOut        <= vout_n;
      if (sof_n) frameCount <= frameCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_stc_frame_tracker.sv
// tb/tb_stc_frame_tracker.sv - directed table-driven bench for stc_frame_tracker
module tb_stc_frame_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clkEn = 1'b0;
  logic        validIn = 1'b0;
  logic        pilotFound = 1'b0;
  logic        startOfFrame, validOut, lastSampleReset, locked;
  logic [1:0]  missCount;
  logic [15:0] frameCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stc_frame_tracker #(
    .FRAME_SAMPLES(64),
    .PILOT_SAMPLES(8),
    .WINDOW(2),
    .MAX_MISSES(3),
    .CNT_W(6)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clkEn          (clkEn),
    .validIn        (validIn),
    .pilotFound     (pilotFound),
    .startOfFrame   (startOfFrame),
    .validOut       (validOut),
    .lastSampleReset(lastSampleReset),
    .locked         (locked),
    .missCount      (missCount),
    .frameCount     (frameCount)
  );

  // rst: reset first; gap: pilot-free strobes before the checked strobe; exp -1 = not checked
  typedef struct {
    int rst;
    int gap;
    int pilot;
    int sof;
    int vout;
    int lock;
    int lsr;
    int miss;
    int fc;
  } vec_t;

  vec_t vecs[37];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    if (exp < 0) return;
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int sof, input int vout, input int lock,
                          input int lsr, input int miss, input int fc);
    chk({tag, " sof"},  {31'b0, startOfFrame},    sof);
    chk({tag, " vout"}, {31'b0, validOut},        vout);
    chk({tag, " lock"}, {31'b0, locked},          lock);
    chk({tag, " lsr"},  {31'b0, lastSampleReset}, lsr);
    chk({tag, " miss"}, {30'b0, missCount},       miss);
    chk({tag, " fc"},   {16'b0, frameCount},      fc);
  endtask

  task automatic tick(input logic p, input logic en, input logic vi);
    pilotFound = p;
    clkEn      = en;
    validIn    = vi;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pilotFound = 1'b0;
    clkEn      = 1'b1;
    validIn    = 1'b1;
    reset      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    //                rst gap p sof v lk lsr m fc
    // Acquire on 10/74, second locked frame at 138
    vecs[0]  = '{1, 10, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0,  0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 62, 1, 1, 0, 1, 0, 0, 1};
    vecs[3]  = '{0,  0, 0, 0, 0, 1, 0, 0, 1};
    vecs[4]  = '{0,  5, 0, 0, 0, 1, 0, 0, 1};
    vecs[5]  = '{0,  0, 0, 0, 1, 1, 0, 0, 1};
    vecs[6]  = '{0, 54, 0, 0, 1, 1, 0, 0, 1};
    vecs[7]  = '{0,  0, 1, 1, 0, 1, 0, 0, 2};
    vecs[8]  = '{0,  0, 0, 0, 0, 1, 0, 0, 2};
    // Early resync at 136, late resync at 201
    vecs[9]  = '{1, 10, 1, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 63, 1, 1, 0, 1, 0, 0, 1};
    vecs[11] = '{0, 61, 1, 1, 0, 1, 0, 0, 2};
    vecs[12] = '{0,  6, 0, 0, 0, 1, 0, 0, 2};
    vecs[13] = '{0,  0, 0, 0, 1, 1, 0, 0, 2};
    vecs[14] = '{0, 55, 0, 0, 0, 1, 0, 0, 2};
    vecs[15] = '{0,  0, 1, 1, 0, 1, 0, 0, 3};
    vecs[16] = '{0,  6, 0, 0, 0, 1, 0, 0, 3};
    vecs[17] = '{0,  0, 0, 0, 1, 1, 0, 0, 3};
    // Flywheel through misses; pilot on the close strobe at 205 is a miss; loss at 269
    vecs[18] = '{1, 10, 1, 0, 0, 0, 0, 0, 0};
    vecs[19] = '{0, 63, 1, 1, 0, 1, 0, 0, 1};
    vecs[20] = '{0, 65, 0, 0, 0, 1, 0, 0, 1};
    vecs[21] = '{0,  0, 0, 1, 0, 1, 0, 1, 2};
    vecs[22] = '{0,  3, 0, 0, 0, 1, 0, 1, 2};
    vecs[23] = '{0,  0, 0, 0, 1, 1, 0, 1, 2};
    vecs[24] = '{0, 58, 1, 1, 0, 1, 0, 2, 3};
    vecs[25] = '{0, 63, 0, -1, 0, 0, 1, 0, -1};
    vecs[26] = '{0,  0, 0, 0, 0, 0, 0, 0, -1};
    // VERIFY miss at 77 back to SEARCH, then fresh acquisition on 78/142
    vecs[27] = '{1, 10, 1, 0, 0, 0, 0, 0, 0};
    vecs[28] = '{0, 63, 0, 0, 0, 0, 0, 0, 0};
    vecs[29] = '{0,  2, 1, 0, 0, 0, 0, 0, 0};
    vecs[30] = '{0,  0, 1, 0, 0, 0, 0, 0, 0};
    vecs[31] = '{0, 63, 1, 1, 0, 1, 0, 0, 1};
    // Two pilots in one window (idx 63 then idx 1): only the first counts
    vecs[32] = '{1, 10, 1, 0, 0, 0, 0, 0, 0};
    vecs[33] = '{0, 63, 1, 1, 0, 1, 0, 0, 1};
    vecs[34] = '{0, 62, 1, 1, 0, 1, 0, 0, 2};
    vecs[35] = '{0,  0, 1, 0, 0, 1, 0, 0, 2};
    vecs[36] = '{0, 62, 1, 1, 0, 1, 0, 0, 3};

    for (int i = 0; i < 37; i++) begin
      if (vecs[i].rst != 0) do_reset();
      repeat (vecs[i].gap) tick(1'b0, 1'b1, 1'b1);
      tick(vecs[i].pilot != 0, 1'b1, 1'b1);
      chk_outs($sformatf("v%0d", i), vecs[i].sof, vecs[i].vout, vecs[i].lock,
               vecs[i].lsr, vecs[i].miss, vecs[i].fc);
    end

    // clkEn freeze mid-frame and async reset
    do_reset();
    repeat (10) tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    repeat (63) tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    repeat (16) tick(1'b0, 1'b1, 1'b1);
    chk_outs("idx16", 0, 1, 1, 0, 0, 1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk_outs("nostrobe", 0, 0, 1, 0, 0, 1);
    tick(1'b0, 1'b1, 1'b1);
    repeat (20) tick(1'b1, 1'b0, 1'b1);
    chk_outs("frozen", 0, 1, 1, 0, 0, 1);
    repeat (46) tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    chk_outs("resume", 1, 0, 1, 0, 0, 2);
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    chk_outs("sofhold", 1, 0, 1, 0, 0, 2);
    tick(1'b0, 1'b1, 1'b1);
    chk_outs("sofdrop", 0, 0, 1, 0, 0, 2);
    repeat (11) tick(1'b0, 1'b1, 1'b1);
    chk_outs("premid", 0, 1, 1, 0, 0, 2);
    #2;
    reset = 1'b0;
    #1;
    chk_outs("asyncrst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
